// File: rtl/ibex_data_bus_router.sv
// Routes one master to NUM_SLAVES address-decoded slaves; grant is combinational, responses return in grant order.
// Issue stalls while the ID queue is full or while a different slave still owes a response; unmapped requests get an error reply.
module ibex_data_bus_router #(
  parameter int unsigned NUM_SLAVES = 8,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_req,
  input  logic                     m_we,
  input  logic [3:0]               m_be,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  output logic                     m_gnt,
  output logic                     m_rvalid,
  output logic                     m_err,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_req,
  output logic                     s_we,
  output logic [3:0]               s_be,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [NUM_SLAVES-1:0]    s_gnt,
  input  logic [NUM_SLAVES-1:0]    s_rvalid,
  input  logic [NUM_SLAVES-1:0]    s_err,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic                     busy,
  output logic                     decode_err
);

  localparam int unsigned IDW  = $clog2(NUM_SLAVES + 1);
  localparam int unsigned PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDW-1:0]  ERR_ID   = IDW'(NUM_SLAVES);
  localparam logic [PTRW-1:0] LAST_PTR = PTRW'(MAX_OUTSTANDING - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(MAX_OUTSTANDING);

  logic [IDW-1:0]  ids [MAX_OUTSTANDING];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic [IDW-1:0]  last_id;
  logic [IDW-1:0]  sel;
  logic [IDW-1:0]  head;
  logic            empty, full, can_issue, slave_gnt, push, pop;
  logic            head_rvalid, head_err;
  logic [31:0]     head_rdata;

  assign s_we    = m_we;
  assign s_be    = m_be;
  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    sel = ERR_ID;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (SLAVE_MASK[32*i +: 32] != 32'h0 &&
          (m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        sel = IDW'(i);
      end
    end
  end

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign can_issue = !full && (empty || sel == last_id);
  assign head      = ids[rd_ptr];
  assign busy      = !empty;

  always_comb begin
    slave_gnt   = 1'b1;
    s_req       = '0;
    head_rvalid = 1'b0;
    head_err    = 1'b0;
    head_rdata  = 32'h0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel == IDW'(i)) begin
        slave_gnt = s_gnt[i];
        s_req[i]  = m_req && can_issue;
      end
      if (head == IDW'(i)) begin
        head_rvalid = s_rvalid[i];
        head_err    = s_err[i];
        head_rdata  = s_rdata[32*i +: 32];
      end
    end
  end

  assign m_gnt = can_issue && slave_gnt;
  assign push  = m_req && m_gnt;

  // An error-slave entry only reaches the head a cycle after its push, so it answers immediately.
  always_comb begin
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    m_rdata  = 32'h0;
    if (!empty) begin
      if (head == ERR_ID) begin
        m_rvalid = 1'b1;
        m_err    = 1'b1;
      end else if (head_rvalid) begin
        m_rvalid = 1'b1;
        m_err    = head_err;
        m_rdata  = head_rdata;
      end
    end
  end

  assign pop = m_rvalid;

  always_ff @(posedge clk) begin
    if (push) begin
      ids[wr_ptr] <= sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_id    <= '0;
      decode_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTRW'(1);
        last_id <= sel;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTRW'(1);
      end
      if (push && !pop) begin
        count <= count + CNTW'(1);
      end else if (pop && !push) begin
        count <= count - CNTW'(1);
      end
      decode_err <= push && (sel == ERR_ID);
    end
  end

endmodule

// File: tb/tb_ibex_data_bus_router.sv
// Bench for ibex_data_bus_router: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ibex_data_bus_router;

  localparam int NS = 3;
  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        m_gnt, m_rvalid, m_err;
  logic [31:0] m_rdata;
  logic [NS-1:0] s_req;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata;
  logic [NS-1:0] s_gnt, s_rvalid, s_err;
  logic [NS*32-1:0] s_rdata;
  logic        busy, decode_err;

  ibex_data_bus_router #(
    .NUM_SLAVES(NS),
    .MAX_OUTSTANDING(MO),
    .SLAVE_BASE({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hF000_0000, 32'hF000_0000, 32'hF000_0000})
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata),
    .busy(busy), .decode_err(decode_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: IDs of granted transactions in issue order.
  int q[$];
  int last_m = 0;
  bit dec_m  = 1'b0;
  bit pp_push, pp_pop;
  int pp_sel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    m_req = 0; m_we = 0; m_be = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
    s_gnt = '0; s_rvalid = '0; s_err = '0; s_rdata = '0;
  endtask

  task automatic sample();
    int sm, h;
    bit can, g, rv, er;
    logic [2:0] sr;
    logic [31:0] rd;
    @(negedge clk);
    sm  = (m_addr[31:28] < 4'd3) ? int'(m_addr[31:28]) : 3;
    can = (q.size() < MO) && (q.size() == 0 || sm == last_m);
    g   = can && ((sm == 3) ? 1'b1 : s_gnt[sm]);
    sr  = (m_req && can && sm < 3) ? 3'(1 << sm) : 3'b000;
    rv = 0; er = 0; rd = 32'h0;
    if (q.size() != 0) begin
      h = q[0];
      if (h == 3) begin
        rv = 1; er = 1;
      end else if (s_rvalid[h]) begin
        rv = 1; er = s_err[h]; rd = s_rdata[32*h +: 32];
      end
    end
    check_eq("m_gnt", 32'(m_gnt), 32'(g));
    check_eq("s_req", 32'(s_req), 32'(sr));
    check_eq("m_rvalid", 32'(m_rvalid), 32'(rv));
    check_eq("m_err", 32'(m_err), 32'(er));
    check_eq("m_rdata", m_rdata, rd);
    check_eq("busy", 32'(busy), 32'(q.size() != 0));
    check_eq("decode_err", 32'(decode_err), 32'(dec_m));
    check_eq("s_bcast", {s_addr ^ s_wdata}, {m_addr ^ m_wdata});
    pp_push = m_req && g;
    pp_pop  = rv;
    pp_sel  = sm;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      q.delete(); last_m = 0; dec_m = 0;
    end else begin
      if (pp_pop) void'(q.pop_front());
      if (pp_push) begin
        q.push_back(pp_sel);
        last_m = pp_sel;
      end
      dec_m = pp_push && (pp_sel == 3);
    end
    #1;
  endtask

  task automatic assert_rst();
    rst = 1;
    q.delete(); last_m = 0; dec_m = 0;
  endtask

  initial begin
    idle();
    assert_rst();
    sample();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rvalid", 32'(m_rvalid), 32'd0);
    step();
    rst = 0;

    // Read from slave 1, response two cycles later.
    m_req = 1; m_addr = 32'h1000_0004; s_gnt = 3'b010;
    sample();
    check_eq("rd_sreq", 32'(s_req), 32'b010);
    check_eq("rd_gnt", 32'(m_gnt), 32'd1);
    step();
    idle();
    sample(); step();
    s_rvalid = 3'b010; s_rdata[32 +: 32] = 32'hCAFE_0001;
    sample();
    check_eq("rd_rvalid", 32'(m_rvalid), 32'd1);
    check_eq("rd_rdata", m_rdata, 32'hCAFE_0001);
    step();
    idle();
    sample();
    check_eq("rd_busy_done", 32'(busy), 32'd0);
    step();

    // Unmapped request.
    m_req = 1; m_addr = 32'h4000_0000;
    sample();
    check_eq("de_gnt", 32'(m_gnt), 32'd1);
    check_eq("de_sreq", 32'(s_req), 32'd0);
    step();
    idle();
    sample();
    check_eq("de_pulse", 32'(decode_err), 32'd1);
    check_eq("de_rvalid", 32'(m_rvalid), 32'd1);
    check_eq("de_err", 32'(m_err), 32'd1);
    check_eq("de_rdata", m_rdata, 32'h0);
    step();
    sample();
    check_eq("de_pulse_end", 32'(decode_err), 32'd0);
    step();

    // Queue-full back-pressure to slave 0.
    m_req = 1; m_addr = 32'h0000_0010; s_gnt = 3'b001;
    sample(); check_eq("full_g1", 32'(m_gnt), 32'd1); step();
    sample(); check_eq("full_g2", 32'(m_gnt), 32'd1); step();
    sample(); check_eq("full_g3", 32'(m_gnt), 32'd0); step();
    s_rvalid = 3'b001;
    sample(); check_eq("full_pop_gnt", 32'(m_gnt), 32'd0); step();
    s_rvalid = 3'b000;
    sample(); check_eq("full_after_pop", 32'(m_gnt), 32'd1); step();
    m_req = 0; s_rvalid = 3'b001;
    sample(); step();
    sample(); step();
    idle();
    sample(); check_eq("full_drained", 32'(busy), 32'd0); step();

    // Ordering: slave 1 must wait behind slave 0; stray slave 2 response ignored.
    m_req = 1; m_addr = 32'h0000_0000; s_gnt = 3'b001;
    sample(); step();
    m_addr = 32'h1000_0000; s_gnt = 3'b111; s_rvalid = 3'b100;
    sample();
    check_eq("ord_gnt", 32'(m_gnt), 32'd0);
    check_eq("ord_sreq", 32'(s_req), 32'd0);
    check_eq("ord_stray", 32'(m_rvalid), 32'd0);
    step();
    s_rvalid = 3'b001;
    sample(); check_eq("ord_gnt_pop", 32'(m_gnt), 32'd0); step();
    s_rvalid = 3'b000;
    sample(); check_eq("ord_gnt_s1", 32'(s_req), 32'b010); step();
    m_req = 0; s_rvalid = 3'b010;
    sample(); step();
    idle();

    // Reset with a transaction in flight.
    m_req = 1; m_addr = 32'h0000_0020; s_gnt = 3'b001;
    sample(); step();
    idle();
    assert_rst();
    sample(); check_eq("mrst_busy", 32'(busy), 32'd0); step();
    rst = 0; s_rvalid = 3'b001; s_rdata[31:0] = 32'h1234_5678;
    sample(); check_eq("mrst_stale", 32'(m_rvalid), 32'd0); step();
    idle();

    for (int n = 0; n < 3000; n++) begin
      m_req    = ($urandom_range(0, 2) != 0);
      m_we     = $urandom_range(0, 1) == 1;
      m_be     = 4'($urandom);
      m_addr   = {4'($urandom_range(0, 5)), 28'($urandom)};
      m_wdata  = $urandom;
      s_gnt    = 3'($urandom);
      s_rvalid = 3'($urandom) & 3'($urandom);
      s_err    = 3'($urandom);
      s_rdata  = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 199) == 0) assert_rst();
      sample();
      step();
      rst = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
